column_renderer: RTL and testbench

Downstream consumer of the per-column ray buffer: takes a raster pixel stream (x, y), reads the column entry for x from the simple dual-port column RAM, and emits one 8-bit RGB332 pixel per input. Each pixel is ceiling, wall, or floor. The block sits between the ray-buffer RAM read port and the video output FIFO/VGA stage. It runs entirely in the read clock domain and has a 3-stage stallable pipeline.

---
 rtl/column_renderer.sv | 170 +++++++++++++++++
 tb/tb_column_renderer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/column_renderer.sv
// Column renderer: turns a raster (x, y) stream into RGB332 pixels by looking up
// per-column wall heights in the ray-buffer RAM. Define COLUMN_RENDERER_SHADE_EN to darken side=1 walls.
module column_renderer #(
  parameter int         DEPTH     = 320,
  parameter int         HEIGHT    = 240,
  parameter int         SIZE      = 32,
  parameter logic [7:0] CEIL_RGB  = 8'h49,
  parameter logic [7:0] FLOOR_RGB = 8'h24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(DEPTH)-1:0]  in_x,
  input  logic [$clog2(HEIGHT)-1:0] in_y,
  input  logic                      in_last,
  output logic [$clog2(DEPTH)-1:0]  raddr,
  input  logic [SIZE-1:0]           read_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_rgb,
  output logic                      out_last,
  output logic                      frame_done
);

  localparam int         YW       = $clog2(HEIGHT);
  localparam logic [9:0] HEIGHT_W = 10'(HEIGHT);

  typedef enum logic [1:0] {REGION_CEIL, REGION_WALL, REGION_FLOOR} region_t;

  logic            adv;
  logic            x_in_range;

  logic            s1_valid, s1_last, s1_oob;
  logic [YW-1:0]   s1_y;
  logic            rw_valid, rw_last, rw_oob;
  logic [YW-1:0]   rw_y;

  logic            hold_valid;
  logic [SIZE-1:0] hold_data;
  logic [SIZE-1:0] rd_word;

  logic [9:0]      hc, top, bot;
  region_t         region_next;
  logic            s2_valid, s2_last, s2_oob;
  region_t         s2_region;
  logic [7:0]      s2_wall_rgb;
  logic [7:0]      wall_px, rgb_next;
  logic            unused_bits;

  assign adv        = !out_valid || out_ready;
  assign in_ready   = adv;
  assign frame_done = out_valid && out_ready && out_last;
  assign x_in_range = 32'(in_x) < DEPTH;

  // S1: register the RAM address and the pixel's side-band data.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_oob   <= 1'b0;
      s1_y     <= '0;
      raddr    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && in_last;
      s1_oob   <= !x_in_range;
      s1_y     <= in_y;
      raddr    <= x_in_range ? in_x : '0;
    end
  end

  // Read-wait slot: side-band data waits here while the RAM returns the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_valid <= 1'b0;
      rw_last  <= 1'b0;
      rw_oob   <= 1'b0;
      rw_y     <= '0;
    end else if (adv) begin
      rw_valid <= s1_valid;
      rw_last  <= s1_last;
      rw_oob   <= s1_oob;
      rw_y     <= s1_y;
    end
  end

  // The RAM keeps reading the held raddr during a stall, which belongs to the
  // pixel behind the waiting one; capture the waiting pixel's word on the first stall edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           hold_valid <= 1'b0;
    else if (adv)         hold_valid <= 1'b0;
    else if (!hold_valid) hold_valid <= 1'b1;
  end

  // NOTE: pure data register qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!adv && !hold_valid) hold_data <= read_data;
  end

  assign rd_word     = hold_valid ? hold_data : read_data;
  assign unused_bits = ^{rd_word[15:9], rd_word[SIZE-1:24]};

  // S2 decode: clamp height, centre the wall vertically, classify the row.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hc          = (10'(rd_word[8:0]) > HEIGHT_W) ? HEIGHT_W : 10'(rd_word[8:0]);
    top         = (HEIGHT_W - hc) >> 1;
    bot         = top + hc;
    region_next = REGION_WALL;
    if (10'(rw_y) < top)       region_next = REGION_CEIL;
    else if (10'(rw_y) >= bot) region_next = REGION_FLOOR;
  end

`ifdef COLUMN_RENDERER_SHADE_EN
  logic s2_side;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_oob      <= 1'b0;
      s2_region   <= REGION_CEIL;
      s2_wall_rgb <= '0;
`ifdef COLUMN_RENDERER_SHADE_EN
      s2_side     <= 1'b0;
`endif
    end else if (adv) begin
      s2_valid    <= rw_valid;
      s2_last     <= rw_last;
      s2_oob      <= rw_oob;
      s2_region   <= region_next;
      s2_wall_rgb <= rd_word[23:16];
`ifdef COLUMN_RENDERER_SHADE_EN
      s2_side     <= rd_word[24];
`endif
    end
  end

  // S3 colour select; shading halves each RGB332 channel.
  always_comb begin
    wall_px = s2_wall_rgb;
`ifdef COLUMN_RENDERER_SHADE_EN
    if (s2_side) wall_px = {1'b0, s2_wall_rgb[7:6], 1'b0, s2_wall_rgb[4:3], 1'b0, s2_wall_rgb[1]};
`endif
    rgb_next = 8'h00;
    if (!s2_oob) begin
      case (s2_region)
        REGION_CEIL:  rgb_next = CEIL_RGB;
        REGION_FLOOR: rgb_next = FLOOR_RGB;
        default:      rgb_next = wall_px;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rgb   <= 8'h00;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_rgb   <= rgb_next;
      out_last  <= s2_last;
    end
  end

endmodule

// File: tb/tb_column_renderer.sv
// Directed self-checking bench for column_renderer: region boundaries, shading,
// clamping, out-of-range columns, random backpressure, frame end and mid-stream reset.
module tb_column_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [8:0]  raddr;
  logic [31:0] read_data;
  logic        out_valid, out_ready, out_last, frame_done;
  logic [7:0]  out_rgb;

  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for raddr appears one cycle later.
  always @(posedge clk) read_data <= mem[raddr];

  column_renderer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .raddr(raddr), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb), .out_last(out_last),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ignored bits are filled with junk so a decode that looks at them shows up.
  function automatic logic [31:0] entry(input logic [8:0] h, input logic [7:0] rgb, input logic side);
    logic [31:0] e;
    e        = 32'h0;
    e[8:0]   = h;
    e[15:9]  = 7'h55;
    e[23:16] = rgb;
    e[24]    = side;
    e[31:25] = 7'h2A;
    return e;
  endfunction

  function automatic logic [7:0] model(input logic [8:0] x, input logic [7:0] y);
    int h, top, yi;
    logic [7:0] w;
    if (x >= 9'd320) return 8'h00;
    h  = int'(mem[x][8:0]);
    if (h > 240) h = 240;
    top = (240 - h) / 2;
    yi  = int'(y);
    if (yi < top) return 8'h49;
    if (yi >= top + h) return 8'h24;
    w = mem[x][23:16];
`ifdef COLUMN_RENDERER_SHADE_EN
    if (mem[x][24]) w = {1'b0, w[7:6], 1'b0, w[4:3], 1'b0, w[1]};
`endif
    return w;
  endfunction

  // One isolated pixel: accept at edge N, check raddr, then output exactly after N+3.
  task automatic single_pixel(input string tag, input logic [8:0] x, input logic [7:0] y,
                              input logic [7:0] exp_rgb);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_last   = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_raddr"}, raddr, (x < 9'd320) ? x : 9'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_rgb"}, out_rgb, exp_rgb);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_q [$];
    logic       exp_lq [$];
    int         cols [6];
    int         sent, got;
    logic       xfer, exp_fd, seen_valid, seen_fd;

    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[5]  = entry(9'd100, 8'hE0, 1'b0);
    mem[7]  = entry(9'd240, 8'hFF, 1'b1);
    mem[9]  = entry(9'd0,   8'hAA, 1'b0);
    mem[11] = entry(9'd400, 8'h1C, 1'b0);
    mem[13] = entry(9'd150, 8'hF4, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rgb", out_rgb, 8'h00);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_raddr", raddr, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    single_pixel("h100_y69", 9'd5, 8'd69, 8'h49);
    single_pixel("h100_y70", 9'd5, 8'd70, 8'hE0);
    single_pixel("h100_y169", 9'd5, 8'd169, 8'hE0);
    single_pixel("h100_y170", 9'd5, 8'd170, 8'h24);
`ifdef COLUMN_RENDERER_SHADE_EN
    single_pixel("shade_side1", 9'd7, 8'd0, 8'h6D);
`else
    single_pixel("shade_side1", 9'd7, 8'd0, 8'hFF);
`endif
    single_pixel("h0_y119", 9'd9, 8'd119, 8'h49);
    single_pixel("h0_y120", 9'd9, 8'd120, 8'h24);
    single_pixel("h400_y0", 9'd11, 8'd0, 8'h1C);
    single_pixel("oob_x320", 9'd320, 8'd33, 8'h00);

    // Backpressure: 16 pixels with random out_ready, last one carries in_last.
    cols = '{5, 7, 9, 11, 13, 320};
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      out_ready = (sent >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sent < 16) begin
        in_valid = 1'b1;
        in_x     = 9'(cols[sent % 6]);
        in_y     = 8'((sent * 37 + 11) % 240);
        in_last  = (sent == 15);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      xfer   = out_valid && out_ready;
      exp_fd = xfer && (exp_lq.size() > 0) && exp_lq[0];
      if (out_valid) begin
        check("bp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("bp_rgb", out_rgb, exp_q[0]);
          check("bp_last", out_last, exp_lq[0]);
        end
      end
      if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
      check("bp_frame_done", frame_done, exp_fd);
      if (xfer && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_lq.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_x, in_y));
        exp_lq.push_back(in_last);
        sent++;
      end
    end
    check("bp_count", got, 16);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Mid-stream reset with three pixels in flight, the oldest stalled at the output.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x     = 9'd5;
      in_y     = 8'(69 + i);
      in_last  = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_raddr", raddr, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    seen_valid = 1'b0;
    seen_fd    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_valid |= out_valid;
      seen_fd    |= frame_done;
    end
    check("post_rst_no_output", seen_valid, 0);
    check("post_rst_no_frame_done", seen_fd, 0);
`ifdef COLUMN_RENDERER_SHADE_EN
    single_pixel("post_rst_pixel", 9'd13, 8'd100, 8'h68);
`else
    single_pixel("post_rst_pixel", 9'd13, 8'd100, 8'hF4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
